// File: rtl/adc_pkg.sv
// Shared constants and helpers for the thermometer-coded converter blocks.
// Used by both the DAC driver and its level decoder.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLEW = 2'd1,
    HOLD = 2'd2
  } dac_state_t;

  localparam int HOLD_CYCLES_DEF = 4;

  function automatic int therm_width(input int bits);
    return 1 << bits;
  endfunction

endpackage

// File: rtl/bin_to_thermometer.sv
// Combinational binary-to-thermometer decoder.
// Level k drives taps [k:0]; tap 0 is therefore always on.
module bin_to_thermometer
  import adc_pkg::*;
#(
  parameter  int BITS    = 2,
  localparam int THERM_W = therm_width(BITS)
) (
  input  logic [BITS-1:0]    level,
  output logic [THERM_W-1:0] therm
);

  always_comb begin
    therm = '0;
    for (int i = 0; i < THERM_W; i++) begin
      therm[i] = (i <= int'(level));
    end
  end

endmodule

// File: rtl/dac_thermometer_driver.sv
// Resistor-string DAC select driver: slews one tap per clock
// toward the accepted code, then holds the settled level.
module dac_thermometer_driver
  import adc_pkg::*;
#(
  parameter  int BITS        = 2,
  localparam int THERM_W     = therm_width(BITS),
  parameter  int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [BITS-1:0]    in_code,
  output logic               in_ready,
  output logic [THERM_W-1:0] therm_out,
  output logic [BITS-1:0]    level_out,
  output logic               busy,
  output logic               done
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

  dac_state_t      state;
  logic [BITS-1:0] level;
  logic [BITS-1:0] target;
  logic [BITS-1:0] lvl_nxt;
  logic [7:0]      hold_cnt;

  // One tap per edge keeps every ladder transition single-bit.
  assign lvl_nxt = (target > level) ? level + 1'b1
                                    : level - 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      level    <= '0;
      target   <= '0;
      hold_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            target <= in_code;
            if (in_code != level) begin
              state <= SLEW;
            end else begin
              state    <= HOLD;
              hold_cnt <= HOLD_INIT;
            end
          end
        end
        SLEW: begin
          level <= lvl_nxt;
          if (lvl_nxt == target) begin
            state    <= HOLD;
            hold_cnt <= HOLD_INIT;
          end
        end
        HOLD: begin
          if (hold_cnt == 8'd0) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == SLEW) || (state == HOLD);
  assign level_out = level;

  bin_to_thermometer #(
    .BITS (BITS)
  ) u_dec (
    .level (level),
    .therm (therm_out)
  );

endmodule

// File: tb/tb_dac_thermometer_driver.sv
// Directed bench for the thermometer DAC driver (BITS=2, HOLD=4).
// Samples outputs 1 time unit after each rising edge.
module tb_dac_thermometer_driver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [1:0] in_code;
  logic       in_ready;
  logic [3:0] therm_out;
  logic [1:0] level_out;
  logic       busy;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dac_thermometer_driver #(
    .BITS        (2),
    .HOLD_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_ready  (in_ready),
    .therm_out (therm_out),
    .level_out (level_out),
    .busy      (busy),
    .done      (done)
  );

  // Reference thermometer encoder: number of set taps minus one.
  function automatic logic [31:0] enc(input logic [3:0] t);
    return 32'($countones(t) - 1);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic [3:0] th,
                    input logic rdy, input logic bsy,
                    input logic dn);
    chk({tag, "_therm"}, 32'(therm_out), 32'(th));
    chk({tag, "_rdy"},   32'(in_ready),  32'(rdy));
    chk({tag, "_busy"},  32'(busy),      32'(bsy));
    chk({tag, "_done"},  32'(done),      32'(dn));
  endtask

  task automatic tick();
    logic [3:0] p;
    p = therm_out;
    @(posedge clk);
    #1;
    chk("loop_enc", 32'(level_out), enc(therm_out));
    chk("loop_valid", 32'(therm_out),
        32'((5'd1 << $countones(therm_out)) - 5'd1));
    chk("one_bit", 32'($countones(p ^ therm_out) <= 1), 32'd1);
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_code  = 2'd0;
    #12;
    st("reset", 4'b0001, 1'b1, 1'b0, 1'b0);
    chk("reset_lvl", 32'(level_out), 32'd0);
    reset_n = 1'b1;

    // Up slew 0 -> 3
    in_valid = 1'b1;
    in_code  = 2'd3;
    tick();
    in_valid = 1'b0;
    st("up_e0", 4'b0001, 1'b0, 1'b1, 1'b0);
    tick(); st("up_e1", 4'b0011, 1'b0, 1'b1, 1'b0);
    tick(); st("up_e2", 4'b0111, 1'b0, 1'b1, 1'b0);
    tick(); st("up_e3", 4'b1111, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); st("up_hold", 4'b1111, 1'b0, 1'b1, 1'b0);
    end
    tick(); st("up_e7", 4'b1111, 1'b1, 1'b0, 1'b1);
    tick(); st("up_e8", 4'b1111, 1'b1, 1'b0, 1'b0);

    // Down slew 3 -> 1
    in_valid = 1'b1;
    in_code  = 2'd1;
    tick();
    in_valid = 1'b0;
    st("dn_e0", 4'b1111, 1'b0, 1'b1, 1'b0);
    tick(); st("dn_e1", 4'b0111, 1'b0, 1'b1, 1'b0);
    tick(); st("dn_e2", 4'b0011, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); st("dn_hold", 4'b0011, 1'b0, 1'b1, 1'b0);
    end
    tick(); st("dn_end", 4'b0011, 1'b1, 1'b0, 1'b1);
    tick(); st("dn_idle", 4'b0011, 1'b1, 1'b0, 1'b0);

    // Equal code: straight to HOLD
    in_valid = 1'b1;
    in_code  = 2'd1;
    tick();
    in_valid = 1'b0;
    st("eq_e0", 4'b0011, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); st("eq_hold", 4'b0011, 1'b0, 1'b1, 1'b0);
    end
    tick(); st("eq_e4", 4'b0011, 1'b1, 1'b0, 1'b1);

    // Continuous valid with code 2, accepted on the done cycle
    in_valid = 1'b1;
    in_code  = 2'd2;
    tick(); st("hs_acc", 4'b0011, 1'b0, 1'b1, 1'b0);
    tick(); st("hs_slew", 4'b0111, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); st("hs_hold", 4'b0111, 1'b0, 1'b1, 1'b0);
    end
    tick(); st("hs_done", 4'b0111, 1'b1, 1'b0, 1'b1);
    tick(); st("hs_b2b", 4'b0111, 1'b0, 1'b1, 1'b0);
    in_code = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick(); st("hs_ignore", 4'b0111, 1'b0, 1'b1, 1'b0);
    end
    in_valid = 1'b0;
    in_code  = 2'd2;
    tick(); st("hs_done2", 4'b0111, 1'b1, 1'b0, 1'b1);
    tick(); st("hs_idle", 4'b0111, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a slew toward 3
    in_valid = 1'b1;
    in_code  = 2'd3;
    tick();
    in_valid = 1'b0;
    st("rs_slew", 4'b0111, 1'b0, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    st("rs_async", 4'b0001, 1'b1, 1'b0, 1'b0);
    chk("rs_lvl", 32'(level_out), 32'd0);
    tick(); st("rs_low", 4'b0001, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick(); st("rs_rel", 4'b0001, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_code  = 2'd1;
    tick();
    in_valid = 1'b0;
    st("rs_acc", 4'b0001, 1'b0, 1'b1, 1'b0);
    tick(); st("rs_e1", 4'b0011, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); st("rs_hold", 4'b0011, 1'b0, 1'b1, 1'b0);
    end
    tick(); st("rs_done", 4'b0011, 1'b1, 1'b0, 1'b1);

    // Random code stream with loopback checks in tick()
    for (int i = 0; i < 120; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_code  = 2'($urandom_range(0, 3));
      tick();
    end
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
